// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: enable levels, slot flags,
// bus widths, dataLen encodings and FSM state encoding.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    localparam logic ENABLE    = 1'b1;
    localparam logic DISABLE   = 1'b0;
    localparam logic SLOT_FREE = 1'b0;
    localparam logic SLOT_BUSY = 1'b1;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_RSVD = 2'b10;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INST = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Index of the last byte of a transfer; the reserved encoding behaves as a word.
    function automatic logic [1:0] len_last(input logic [1:0] len);
        case (len)
            LEN_BYTE:           return 2'd0;
            LEN_HALF:           return 2'd1;
            LEN_RSVD, LEN_WORD: return 2'd3;
            default:            return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetches and data
// loads/stores onto a single 8-bit RAM port, data taking priority.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        instEn,
    input  logic [31:0] instAddr,
    output logic        memInstOutEn,
    output logic [31:0] memInst,
    input  logic        dataEn,
    input  logic        dataWr,
    input  logic [31:0] dataAddr,
    input  logic [1:0]  dataLen,
    input  logic [31:0] dataIn,
    output logic        dataOutEn,
    output logic [31:0] dataOut,
    input  logic [7:0]  ramDin,
    output logic [7:0]  ramDout,
    output logic [31:0] ramAddr,
    output logic        ramWr
);

    state_t state, state_nx;

    logic              inst_pend, data_pend;
    logic [ADDR_W-1:0] inst_addr_q, data_addr_q;
    logic [1:0]        data_len_q;
    logic              data_wr_q;
    logic [DATA_W-1:0] data_in_q;

    logic [1:0]        cnt, last_q;
    logic              wr_q, ramwr_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, rbuf;

    logic              start_data, start_inst, last_byte;
    logic [ADDR_W-1:0] st_addr;
    logic [1:0]        st_last;
    logic              st_wr;
    logic [DATA_W-1:0] st_wdata, rdata_nx;

    function automatic logic [BYTE_W-1:0] get_byte(input logic [DATA_W-1:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                   input logic [BYTE_W-1:0] b,
                                                   input logic [1:0] i);
        logic [DATA_W-1:0] r;
        r = w;
        case (i)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // The RAM never sees a write strobe while it is not ready.
    assign ramWr = ramwr_q & rdy;

    always_comb begin
        state_nx   = state;
        start_data = (data_pend == SLOT_BUSY) || (dataEn == ENABLE);
        start_inst = (inst_pend == SLOT_BUSY) || (instEn == ENABLE);
        st_addr    = (inst_pend == SLOT_BUSY) ? inst_addr_q : instAddr;
        st_last    = 2'd3;
        st_wr      = DISABLE;
        st_wdata   = '0;
        if (start_data) begin
            st_addr  = (data_pend == SLOT_BUSY) ? data_addr_q : dataAddr;
            st_last  = len_last((data_pend == SLOT_BUSY) ? data_len_q : dataLen);
            st_wr    = (data_pend == SLOT_BUSY) ? data_wr_q : dataWr;
            st_wdata = (data_pend == SLOT_BUSY) ? data_in_q : dataIn;
        end
        last_byte = (cnt == last_q);
        rdata_nx  = put_byte(rbuf, ramDin, cnt);
        case (state)
            ST_IDLE: begin
                if (rdy) begin
                    if (start_data)      state_nx = ST_DATA;
                    else if (start_inst) state_nx = ST_INST;
                end
            end
            ST_INST, ST_DATA: begin
                if (rdy && last_byte) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Control and externally visible registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            inst_pend    <= SLOT_FREE;
            data_pend    <= SLOT_FREE;
            cnt          <= 2'd0;
            last_q       <= 2'd0;
            wr_q         <= DISABLE;
            ramwr_q      <= DISABLE;
            ramAddr      <= '0;
            ramDout      <= '0;
            memInstOutEn <= DISABLE;
            dataOutEn    <= DISABLE;
            memInst      <= '0;
            dataOut      <= '0;
        end else begin
            state        <= state_nx;
            memInstOutEn <= DISABLE;
            dataOutEn    <= DISABLE;
            if (instEn) inst_pend <= SLOT_BUSY;
            if (dataEn) data_pend <= SLOT_BUSY;
            if (state == ST_IDLE) begin
                if (state_nx != ST_IDLE) begin
                    cnt     <= 2'd0;
                    last_q  <= st_last;
                    wr_q    <= st_wr;
                    ramwr_q <= st_wr;
                    ramAddr <= st_addr;
                    ramDout <= st_wr ? get_byte(st_wdata, 2'd0) : '0;
                end
            end else if (rdy) begin
                if (last_byte) begin
                    ramAddr <= '0;
                    ramDout <= '0;
                    ramwr_q <= DISABLE;
                    if (state == ST_INST) begin
                        memInstOutEn <= ENABLE;
                        memInst      <= rdata_nx;
                        inst_pend    <= SLOT_FREE;
                    end else begin
                        dataOutEn <= ENABLE;
                        data_pend <= SLOT_FREE;
                        if (!wr_q) dataOut <= rdata_nx;
                    end
                end else begin
                    cnt     <= cnt + 2'd1;
                    ramAddr <= base_q + {30'd0, cnt + 2'd1};
                    ramDout <= wr_q ? get_byte(wdata_q, cnt + 2'd1) : '0;
                    ramwr_q <= wr_q;
                end
            end
        end
    end

    // Request slots and transfer datapath; contents only matter once qualified.
    always_ff @(posedge clk) begin
        if (instEn) inst_addr_q <= instAddr;
        if (dataEn) begin
            data_addr_q <= dataAddr;
            data_len_q  <= dataLen;
            data_wr_q   <= dataWr;
            data_in_q   <= dataIn;
        end
        if (state == ST_IDLE) begin
            if (state_nx != ST_IDLE) begin
                base_q  <= st_addr;
                wdata_q <= st_wdata;
                rbuf    <= '0;
            end
        end else if (rdy && !wr_q) begin
            rbuf <= rdata_nx;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, vector table and
// completion scoreboard checked for value, kind and cycle of arrival.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        instEn = 1'b0;
    logic [31:0] instAddr = '0;
    logic        memInstOutEn;
    logic [31:0] memInst;
    logic        dataEn = 1'b0;
    logic        dataWr = 1'b0;
    logic [31:0] dataAddr = '0;
    logic [1:0]  dataLen = 2'b00;
    logic [31:0] dataIn = '0;
    logic        dataOutEn;
    logic [31:0] dataOut;
    logic [7:0]  ramDin;
    logic [7:0]  ramDout;
    logic [31:0] ramAddr;
    logic        ramWr;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .instEn(instEn), .instAddr(instAddr),
        .memInstOutEn(memInstOutEn), .memInst(memInst),
        .dataEn(dataEn), .dataWr(dataWr), .dataAddr(dataAddr),
        .dataLen(dataLen), .dataIn(dataIn),
        .dataOutEn(dataOutEn), .dataOut(dataOut),
        .ramDin(ramDin), .ramDout(ramDout), .ramAddr(ramAddr), .ramWr(ramWr)
    );

    always #5 clk = ~clk;

    // RAM: combinational read, so the byte for an address is valid at the next edge.
    logic [7:0] mem [0:1023];
    assign ramDin = mem[ramAddr[9:0]];
    always @(posedge clk) if (ramWr) mem[ramAddr[9:0]] <= ramDout;

    int cyc = 0;
    int wr_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ramWr) wr_cnt <= wr_cnt + 1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_data;
        logic [31:0] val;
        logic        chk_val;
        int          cyc;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        int          wrs;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input logic is_data, input logic [31:0] val, input string nm);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected: got done pulse at cycle %0d, expected none", nm, cyc);
        end else begin
            e = sb.pop_front();
            chk({nm, "_kind"}, {31'd0, is_data}, {31'd0, e.is_data});
            if (e.chk_val) chk({nm, "_value"}, val, e.val);
            chk({nm, "_cycle"}, cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (memInstOutEn) pop_chk(1'b0, memInst, "fetch");
            if (dataOutEn)    pop_chk(1'b1, dataOut, "data");
        end
    end

    task automatic push(input logic is_data, input logic [31:0] val, input logic chk_val, input int c);
        sb_t e;
        e.is_data = is_data;
        e.val     = val;
        e.chk_val = chk_val;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d completions outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic idle_chk(input string nm);
        chk({nm, "_idle_wr"},   {31'd0, ramWr}, 32'd0);
        chk({nm, "_idle_addr"}, ramAddr, 32'd0);
        chk({nm, "_idle_dout"}, {24'd0, ramDout}, 32'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   wbase;
        string nm;
        v  = vecs[i];
        nm = $sformatf("v%0d", i);
        @(negedge clk);
        wbase = wr_cnt;
        if (v.is_data) begin
            dataEn = 1'b1; dataWr = v.wr; dataAddr = v.addr; dataLen = v.len; dataIn = v.wdata;
        end else begin
            instEn = 1'b1; instAddr = v.addr;
        end
        push(v.is_data, v.exp, !v.wr, cyc + 1 + v.lat);
        @(negedge clk);
        instEn = 1'b0;
        dataEn = 1'b0;
        drain(20);
        @(negedge clk);
        chk({nm, "_wr_count"}, wr_cnt - wbase, v.wrs);
        idle_chk(nm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        mem[10'h100] <= 8'h13; mem[10'h101] <= 8'h05;
        mem[10'h201] <= 8'h34; mem[10'h202] <= 8'h12;
        mem[10'h3FE] <= 8'h11; mem[10'h3FF] <= 8'h22;
        mem[10'h000] <= 8'h33; mem[10'h001] <= 8'h44;

        vecs[0]  = '{is_data:1'b0, wr:1'b0, len:2'b11, addr:32'h100,      wdata:32'h0,        exp:32'h00000513, lat:4, wrs:0};
        vecs[1]  = '{is_data:1'b1, wr:1'b0, len:2'b01, addr:32'h201,      wdata:32'h0,        exp:32'h00001234, lat:2, wrs:0};
        vecs[2]  = '{is_data:1'b1, wr:1'b1, len:2'b11, addr:32'h200,      wdata:32'hDEADBEEF, exp:32'h0,        lat:4, wrs:4};
        vecs[3]  = '{is_data:1'b1, wr:1'b0, len:2'b11, addr:32'h200,      wdata:32'h0,        exp:32'hDEADBEEF, lat:4, wrs:0};
        vecs[4]  = '{is_data:1'b1, wr:1'b0, len:2'b00, addr:32'h203,      wdata:32'h0,        exp:32'h000000DE, lat:1, wrs:0};
        vecs[5]  = '{is_data:1'b1, wr:1'b1, len:2'b00, addr:32'h300,      wdata:32'h123456A5, exp:32'h0,        lat:1, wrs:1};
        vecs[6]  = '{is_data:1'b1, wr:1'b0, len:2'b11, addr:32'h300,      wdata:32'h0,        exp:32'h000000A5, lat:4, wrs:0};
        vecs[7]  = '{is_data:1'b1, wr:1'b1, len:2'b01, addr:32'h310,      wdata:32'hFFFF1234, exp:32'h0,        lat:2, wrs:2};
        vecs[8]  = '{is_data:1'b1, wr:1'b0, len:2'b10, addr:32'h310,      wdata:32'h0,        exp:32'h00001234, lat:4, wrs:0};
        vecs[9]  = '{is_data:1'b1, wr:1'b0, len:2'b11, addr:32'hFFFFFFFE, wdata:32'h0,        exp:32'h44332211, lat:4, wrs:0};
        vecs[10] = '{is_data:1'b0, wr:1'b0, len:2'b00, addr:32'h202,      wdata:32'h0,        exp:32'h0000DEAD, lat:4, wrs:0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_instEn",  {31'd0, memInstOutEn}, 32'd0);
        chk("rst_dataEn",  {31'd0, dataOutEn}, 32'd0);
        chk("rst_memInst", memInst, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        idle_chk("rst");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i);
        chk("store_b0", {24'd0, mem[10'h200]}, 32'hEF);
        chk("store_b3", {24'd0, mem[10'h203]}, 32'hDE);

        // Simultaneous fetch and load: data first, fetch after one Idle edge
        @(negedge clk);
        instEn = 1'b1; instAddr = 32'h100;
        dataEn = 1'b1; dataWr = 1'b0; dataAddr = 32'h201; dataLen = 2'b01;
        push(1'b1, 32'h0000ADBE, 1'b1, cyc + 3);
        push(1'b0, 32'h00000513, 1'b1, cyc + 8);
        @(negedge clk);
        instEn = 1'b0; dataEn = 1'b0;
        drain(40);
        repeat (4) @(negedge clk);
        idle_chk("both");

        // rdy low three edges during a fetch
        @(negedge clk);
        instEn = 1'b1; instAddr = 32'h100;
        push(1'b0, 32'h00000513, 1'b1, cyc + 8);
        @(negedge clk);
        instEn = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_fetch_addr", ramAddr, 32'h101);
        end
        rdy = 1'b1;
        drain(20);

        // rdy low two edges during a store: strobe suppressed, byte held
        @(negedge clk);
        dataEn = 1'b1; dataWr = 1'b1; dataAddr = 32'h320; dataLen = 2'b11; dataIn = 32'hCAFEF00D;
        push(1'b1, 32'h0, 1'b0, cyc + 7);
        @(negedge clk);
        dataEn = 1'b0;
        @(negedge clk);
        rdy = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("stall_st_wr",   {31'd0, ramWr}, 32'd0);
            chk("stall_st_addr", ramAddr, 32'h321);
            chk("stall_st_dout", {24'd0, ramDout}, 32'hF0);
        end
        rdy = 1'b1;
        drain(20);
        @(negedge clk);
        chk("stall_st_word", {mem[10'h323], mem[10'h322], mem[10'h321], mem[10'h320]}, 32'hCAFEF00D);

        // Reset in the middle of a store, after two bytes reached RAM
        @(negedge clk);
        dataEn = 1'b1; dataWr = 1'b1; dataAddr = 32'h380; dataLen = 2'b11; dataIn = 32'h11223344;
        @(negedge clk);
        dataEn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_wr",     {31'd0, ramWr}, 32'd0);
        chk("abort_addr",   ramAddr, 32'd0);
        chk("abort_doneEn", {31'd0, dataOutEn}, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_mem", {mem[10'h383], mem[10'h382], mem[10'h381], mem[10'h380]}, 32'h00003344);
        run_vec(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk in, rst in.
REQ-002 The block SHALL have these ports:
  clk           input   1   system clock, all state on rising edge
  rst           input   1   synchronous active-high reset
  rdy           input   1   RAM ready; low = freeze transfer progress
  instEn        input   1   fetch read request, one-cycle pulse
  instAddr      input   32  fetch word address
  memInstOutEn  output  1   fetch data valid, one-cycle pulse
  memInst       output  32  fetched instruction, little-endian
  dataEn        input   1   load/store request, one-cycle pulse
  dataWr        input   1   1 = store, 0 = load
  dataAddr      input   32  load/store byte address
  dataLen       input   2   00 byte, 01 half, 11 word (10 illegal)
  dataIn        input   32  store data, low bytes used
  dataOutEn     output  1   load/store done, one-cycle pulse
  dataOut       output  32  load data, zero-extended
  ramDin        input   8   RAM read byte, valid one cycle after its address
  ramDout       output  8   RAM write byte
  ramAddr       output  32  RAM byte address
  ramWr         output  1   RAM write strobe

Function
REQ-003 Request pulses SHALL be latched into one pending slot per requester (address, length, write flag, data), including pulses that arrive during another transfer.
REQ-004 States SHALL be Idle, Inst and Data; a transfer SHALL never be pre-empted.
REQ-005 In Idle with a pending slot or a live request pulse, the block SHALL start the transfer at that edge (E0); Data SHALL win over Inst when both are present.
REQ-006 Transfer length N: Inst is 4; Data is 1, 2 or 4 from dataLen.
REQ-007 After edge E0+k (k = 0..N-1), ramAddr SHALL be base+k; for stores, ramDout SHALL be byte k of dataIn and ramWr SHALL be 1.
REQ-008 For reads, ramDin sampled at edge E0+k+1 SHALL be placed in bits [8k+7:8k]; unread upper bytes SHALL be 0.
REQ-009 At edge E0+N the block SHALL pulse the matching done output for exactly one cycle, present read data on memInst or dataOut, clear the pending slot and return to Idle.
REQ-010 memInst and dataOut SHALL hold their last value until the next completion.
REQ-011 In Idle, ramWr SHALL be 0, ramAddr 0 and ramDout 0.
REQ-012 While rdy is 0, the following SHALL apply: ramWr forced to 0; byte counter, state and outputs held; no ramDin sampling; pending-slot latching still active. Progress SHALL resume on the first edge with rdy = 1, re-issuing the held byte.
REQ-013 A second pulse from a requester whose slot is still pending SHALL be a protocol violation and need not be handled; the requester waits for its done pulse.
REQ-014 dataLen = 10 SHALL be treated as word.
REQ-015 The counter SHALL be 2 bits; addresses SHALL wrap modulo 2^32.

Reset
REQ-016 On rst = 1 at a clock edge, the following SHALL apply: state to Idle; pending slots cleared; memInstOutEn, dataOutEn and ramWr to 0; ramAddr, ramDout, memInst and dataOut to 0.
REQ-017 A reset during a transfer SHALL abort it with no done pulse; the partial write is not undone.

Structure
REQ-018 Enable/Disable, addrFree/dataFree, bus widths, dataLen encodings and state encodings SHALL live in the shared defines.v.
REQ-019 The block SHALL be a single module with no sub-module.

Verification
REQ-020 The bench SHALL cover these scenarios:
  - Fetch 0x100, RAM bytes 13 05 00 00 -> memInstOutEn one cycle at E0+4, memInst = 0x00000513; ramWr stays 0.
  - Store word 0xDEADBEEF @0x200 -> ramWr 1 for 4 cycles, bytes EF BE AD DE at 0x200..0x203; dataOutEn at E0+4.
  - Load half @0x201 over bytes 34 12 -> dataOut = 0x00001234, dataOutEn at E0+2.
  - instEn and dataEn in the same cycle -> data finishes first, fetch starts after Idle; both complete once.
  - rdy low 3 cycles mid-word-fetch -> completion delayed exactly 3 cycles, data unchanged.
  - rst mid-store after 2 bytes -> no dataOutEn, ramWr 0 next cycle, later fetch correct.
